lname_mbus_master_pwr_seq: RTL
==============================

// Module: lname_mbus_master_pwr_seq
// PURPOSE
//  Parametrised MBus master power/wire controller for the always-on domain.
//  Sequences MBC_SLEEP/ISOLATE/RESET through a registered FSM with programmable step delays.
//  Supports N sleep-request and M maskable wakeup-request channels and records which source
//  raised the external interrupt. Gates COUT/DOUT onto the bus and drives the DOUT wake pulse.
// PARAMETERS
//  NUM_SLP    2  number of SLEEP_REQ channels (>=1)
//  NUM_WAK    4  number of WAKEUP_REQ channels (>=1)
//  ISO_DLY    1  cycles in UNSLEEP before isolation release (>=1)
//  RST_DLY    1  cycles in UNISO before reset release (>=1)
//  SLP_DLY    1  cycles in ISO before sleep assert (>=1)
// PORTS
//  CLK               in  1        master clock
//  rst_tran_to_wake  in  1        reset, asynchronous, active-high
//  CIN, DIN          in  1        bus clock/data in
//  COUT_FROM_BUS     in  1        clock from bus controller
//  DOUT_FROM_BUS     in  1        data from bus controller
//  COUT, DOUT        out 1        gated bus clock/data out
//  SLEEP_REQ         in  NUM_SLP  sleep requests, level, OR-combined
//  WAKEUP_REQ        in  NUM_WAK  wakeup requests, level
//  WAKEUP_MASK       in  NUM_WAK  1 = channel ignored
//  MBC_ISOLATE(_B)   out 1        isolation, registered (+inverse)
//  MBC_RESET(_B)     out 1        controller reset, registered (+inverse)
//  MBC_SLEEP(_B)     out 1        power gate = sleep_int & DIN (+inverse)
//  CLR_EXT_INT       in  1        clear interrupt/source record
//  EXTERNAL_INT      out 1        interrupt to bus controller
//  WAKE_SRC          out NUM_WAK  sticky record of unmasked requests at interrupt
//  SEQ_BUSY          out 1        1 in UNSLEEP/UNISO/ISO
//  LRC_SLEEP         in  1        layer controller asleep
//  MBUS_BUSY         in  1        bus transaction in progress
// BEHAVIOUR
//  Reset values: state=SLEEP, sleep_int=1, MBC_ISOLATE=1, MBC_RESET=1, EXTERNAL_INT=0,
//   WAKE_SRC=0, ext_int_dout=0, delay counter=0. While reset is high: COUT=1, DOUT=1.
//  Outputs per state (sleep_int/ISO/RST): SLEEP 1/1/1, UNSLEEP 0/1/1, UNISO 0/0/1,
//   ACTIVE 0/0/0, ISO 0/1/1. All are registered and take their values on state entry.
//  State transitions (all evaluated at posedge CLK):
//   - SLEEP -> UNSLEEP when DIN==0.
//   - UNSLEEP -> UNISO after ISO_DLY cycles.
//   - UNISO -> ACTIVE after RST_DLY cycles.
//   - ACTIVE -> ISO when |SLEEP_REQ is high.
//   - ISO -> SLEEP after SLP_DLY cycles.
//   - ISO -> UNISO if DIN==0; the wake abort takes priority over delay expiry.
//  The delay counter clears on every state entry. Its width is $clog2(max delay + 1).
//  SLEEP_REQ is ignored outside ACTIVE. A request held high is taken on ACTIVE entry + 1.
//  Default delays give: DIN low at edge n -> ISOLATE=0 at n+1 -> RESET=0 at n+2.
//  int_busy = |(WAKEUP_REQ & ~WAKEUP_MASK) & ~(MBUS_BUSY & ~MBC_RESET) & LRC_SLEEP.
//   A rising edge of int_busy (registered prev value) sets ext_int_dout=1 and EXTERNAL_INT=1,
//   and ORs the unmasked requests into WAKE_SRC.
//  ext_int_dout clears at the first edge where CIN==0.
//  EXTERNAL_INT and WAKE_SRC clear at an edge where CLR_EXT_INT & ~MBC_ISOLATE.
//   If a set and a clear occur on the same edge, the set wins.
//  COUT = reset ? 1 : ISO ? 1 : COUT_FROM_BUS.
//  DOUT = reset ? 1 : ext_int_dout ? 0 : ISO ? 1 : DOUT_FROM_BUS.
//  Reset asserted mid-sequence forces the SLEEP reset values immediately. No partial state survives.
// TESTING
//  1. Reset, DIN=1 -> SLEEP, ISO=RST=1, MBC_SLEEP=1, COUT=DOUT=1.
//  2. DIN low at edge n, default delays -> MBC_SLEEP=0 immediately; ISO=0 at n+1; RST=0 at n+2;
//     SEQ_BUSY high for n..n+1.
//  3. ISO_DLY=3, RST_DLY=2, SLP_DLY=4: wake then SLEEP_REQ[1]=1 -> ISO falls at n+3,
//     RST falls at n+5, ISO rises at n+6, SLEEP at n+10.
//  4. In ISO, DIN=0 on the SLP_DLY expiry edge -> UNISO (abort), never reaches SLEEP.
//  5. LRC_SLEEP=1, MASK=4'b0010, REQ=4'b0110 -> DOUT=0, EXTERNAL_INT=1, WAKE_SRC=4'b0100;
//     CIN low clears DOUT hold; CLR_EXT_INT in ACTIVE clears INT and WAKE_SRC.
//  6. CLR_EXT_INT on the same edge as a new int_busy rise -> EXTERNAL_INT stays 1.

Source files
------------

// File: rtl/lname_mbus_master_pwr_seq_if.sv
// Bus-side signal bundle for the MBus master power/wire controller.
// master modport: seen from the controller (lname_mbus_master_pwr_seq).
// slave modport : seen from the environment that drives requests and bus wires.
// Signals:
//   CIN, DIN                 bus clock/data in
//   COUT_FROM_BUS/DOUT_FROM_BUS  clock/data from the bus controller
//   COUT, DOUT               gated bus clock/data out
//   SLEEP_REQ   [NUM_SLP]    sleep requests (level, OR-combined)
//   WAKEUP_REQ  [NUM_WAK]    wakeup requests (level)
//   WAKEUP_MASK [NUM_WAK]    1 = channel ignored
//   MBC_ISOLATE/_B, MBC_RESET/_B, MBC_SLEEP/_B  power-domain controls
//   CLR_EXT_INT, EXTERNAL_INT, WAKE_SRC         interrupt handshake
//   SEQ_BUSY, LRC_SLEEP, MBUS_BUSY              status
interface lname_mbus_master_pwr_seq_if #(
  parameter int NUM_SLP = 2,
  parameter int NUM_WAK = 4
);
  logic               CIN;
  logic               DIN;
  logic               COUT_FROM_BUS;
  logic               DOUT_FROM_BUS;
  logic               COUT;
  logic               DOUT;
  logic [NUM_SLP-1:0] SLEEP_REQ;
  logic [NUM_WAK-1:0] WAKEUP_REQ;
  logic [NUM_WAK-1:0] WAKEUP_MASK;
  logic               MBC_ISOLATE;
  logic               MBC_ISOLATE_B;
  logic               MBC_RESET;
  logic               MBC_RESET_B;
  logic               MBC_SLEEP;
  logic               MBC_SLEEP_B;
  logic               CLR_EXT_INT;
  logic               EXTERNAL_INT;
  logic [NUM_WAK-1:0] WAKE_SRC;
  logic               SEQ_BUSY;
  logic               LRC_SLEEP;
  logic               MBUS_BUSY;

  modport master (
    input  CIN, DIN, COUT_FROM_BUS, DOUT_FROM_BUS,
    input  SLEEP_REQ, WAKEUP_REQ, WAKEUP_MASK,
    input  CLR_EXT_INT, LRC_SLEEP, MBUS_BUSY,
    output COUT, DOUT,
    output MBC_ISOLATE, MBC_ISOLATE_B, MBC_RESET, MBC_RESET_B,
    output MBC_SLEEP, MBC_SLEEP_B,
    output EXTERNAL_INT, WAKE_SRC, SEQ_BUSY
  );

  modport slave (
    output CIN, DIN, COUT_FROM_BUS, DOUT_FROM_BUS,
    output SLEEP_REQ, WAKEUP_REQ, WAKEUP_MASK,
    output CLR_EXT_INT, LRC_SLEEP, MBUS_BUSY,
    input  COUT, DOUT,
    input  MBC_ISOLATE, MBC_ISOLATE_B, MBC_RESET, MBC_RESET_B,
    input  MBC_SLEEP, MBC_SLEEP_B,
    input  EXTERNAL_INT, WAKE_SRC, SEQ_BUSY
  );
endinterface

// File: rtl/lname_mbus_master_pwr_seq.sv
// MBus master power/wire controller for the always-on domain.
// Sequences MBC_SLEEP/ISOLATE/RESET with programmable step delays, latches
// which unmasked wakeup channel raised the external interrupt, and gates the
// bus clock/data outputs (including the DOUT-low wake pulse).
// Ports:
//   CLK               master clock
//   rst_tran_to_wake  asynchronous, active-high reset
//   bus               lname_mbus_master_pwr_seq_if.master (all bus/handshake signals)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_SLEEP   | domain powered off, isolated, held in reset
// ST_UNSLEEP | power on, waiting ISO_DLY before isolation release
// ST_UNISO   | isolation released, waiting RST_DLY before reset release
// ST_ACTIVE  | domain running
// ST_ISO     | isolated + reset, waiting SLP_DLY before power off
module lname_mbus_master_pwr_seq #(
  parameter int NUM_SLP = 2,
  parameter int NUM_WAK = 4,
  parameter int ISO_DLY = 1,
  parameter int RST_DLY = 1,
  parameter int SLP_DLY = 1
) (
  input  logic                          CLK,
  input  logic                          rst_tran_to_wake,
  lname_mbus_master_pwr_seq_if.master   bus
);

  localparam int MAX_DLY = (ISO_DLY > RST_DLY) ?
                           ((ISO_DLY > SLP_DLY) ? ISO_DLY : SLP_DLY) :
                           ((RST_DLY > SLP_DLY) ? RST_DLY : SLP_DLY);
  localparam int CW = $clog2(MAX_DLY + 1);

  // A step of D cycles expires when the counter (cleared on entry) reaches D-1.
  localparam logic [CW-1:0] ISO_LAST = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_DLY - 1);
  localparam logic [CW-1:0] SLP_LAST = CW'(SLP_DLY - 1);

  typedef enum logic [2:0] {
    ST_SLEEP   = 3'd0,
    ST_UNSLEEP = 3'd1,
    ST_UNISO   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_ISO     = 3'd4
  } state_t;

  state_t               state;
  state_t               nxt;
  logic [CW-1:0]        cnt;
  logic                 sleep_q;
  logic                 iso_q;
  logic                 rst_q;
  logic                 timed;

  logic [NUM_SLP-1:0]   slp_req;
  logic [NUM_WAK-1:0]   wak_live;
  logic                 int_busy;
  logic                 int_prev;
  logic                 int_rise;
  logic                 int_clr;
  logic                 ext_int_dout;
  logic                 ext_int_q;
  logic [NUM_WAK-1:0]   wake_src_q;

  assign slp_req = bus.SLEEP_REQ;
  assign timed   = (state == ST_UNSLEEP) || (state == ST_UNISO) || (state == ST_ISO);

  always_comb begin
    nxt = state;
    case (state)
      ST_SLEEP:   if (!bus.DIN)        nxt = ST_UNSLEEP;
      ST_UNSLEEP: if (cnt == ISO_LAST) nxt = ST_UNISO;
      ST_UNISO:   if (cnt == RST_LAST) nxt = ST_ACTIVE;
      ST_ACTIVE:  if (|slp_req)        nxt = ST_ISO;
      // A wake during the power-down wait wins over the delay expiring.
      ST_ISO: begin
        if (!bus.DIN)              nxt = ST_UNISO;
        else if (cnt == SLP_LAST)  nxt = ST_SLEEP;
      end
      default:                     nxt = ST_SLEEP;
    endcase
  end

  // Outputs are loaded from the next state so they change on state entry.
  always_ff @(posedge CLK or posedge rst_tran_to_wake) begin
    if (rst_tran_to_wake) begin
      state   <= ST_SLEEP;
      cnt     <= '0;
      sleep_q <= 1'b1;
      iso_q   <= 1'b1;
      rst_q   <= 1'b1;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (timed)
        cnt <= cnt + CW'(1);
      case (nxt)
        ST_SLEEP:   begin sleep_q <= 1'b1; iso_q <= 1'b1; rst_q <= 1'b1; end
        ST_UNSLEEP: begin sleep_q <= 1'b0; iso_q <= 1'b1; rst_q <= 1'b1; end
        ST_UNISO:   begin sleep_q <= 1'b0; iso_q <= 1'b0; rst_q <= 1'b1; end
        ST_ACTIVE:  begin sleep_q <= 1'b0; iso_q <= 1'b0; rst_q <= 1'b0; end
        ST_ISO:     begin sleep_q <= 1'b0; iso_q <= 1'b1; rst_q <= 1'b1; end
        default:    begin sleep_q <= 1'b1; iso_q <= 1'b1; rst_q <= 1'b1; end
      endcase
    end
  end

  // Bus activity only blocks the interrupt while the controller is out of reset.
  assign wak_live = bus.WAKEUP_REQ & ~bus.WAKEUP_MASK;
  assign int_busy = (|wak_live) & ~(bus.MBUS_BUSY & ~rst_q) & bus.LRC_SLEEP;
  assign int_rise = int_busy & ~int_prev;
  assign int_clr  = bus.CLR_EXT_INT & ~iso_q;

  always_ff @(posedge CLK or posedge rst_tran_to_wake) begin
    if (rst_tran_to_wake) begin
      int_prev     <= 1'b0;
      ext_int_dout <= 1'b0;
      ext_int_q    <= 1'b0;
      wake_src_q   <= '0;
    end else begin
      int_prev <= int_busy;
      if (int_rise)
        ext_int_dout <= 1'b1;
      else if (!bus.CIN)
        ext_int_dout <= 1'b0;
      // A new interrupt on the clearing edge must not be lost.
      if (int_rise) begin
        ext_int_q  <= 1'b1;
        wake_src_q <= wake_src_q | wak_live;
      end else if (int_clr) begin
        ext_int_q  <= 1'b0;
        wake_src_q <= '0;
      end
    end
  end

  assign bus.MBC_ISOLATE   = iso_q;
  assign bus.MBC_ISOLATE_B = ~iso_q;
  assign bus.MBC_RESET     = rst_q;
  assign bus.MBC_RESET_B   = ~rst_q;
  assign bus.MBC_SLEEP     = sleep_q & bus.DIN;
  assign bus.MBC_SLEEP_B   = ~(sleep_q & bus.DIN);
  assign bus.EXTERNAL_INT  = ext_int_q;
  assign bus.WAKE_SRC      = wake_src_q;
  assign bus.SEQ_BUSY      = timed;

  assign bus.COUT = rst_tran_to_wake | iso_q | bus.COUT_FROM_BUS;
  assign bus.DOUT = rst_tran_to_wake ? 1'b1 :
                    ext_int_dout     ? 1'b0 :
                    iso_q            ? 1'b1 : bus.DOUT_FROM_BUS;

endmodule
